uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 27 ++
 rtl/uart_tx_shift.sv | 117 +++++++++++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the three-requester UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int NREQ       = 3;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Clock cycles per serial bit; never below one so the counters stay sane.
    function automatic int calc_period(input int clk_freq, input int baud);
        return ((clk_freq / baud) < 1) ? 1 : (clk_freq / baud);
    endfunction

    // (p + k) mod 3 for requester indices.
    function automatic logic [1:0] add_mod3(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// 8N1 serialiser: start bit, 8 data bits LSB first, stop bit, PERIOD cycles each.
// A load presented in the final STOP cycle chains straight into the next START.
module uart_tx_shift
    import uart_tx_arbiter_pkg::*;
#(
    parameter int PERIOD = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o,
    output logic       idle_o
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          done_s;
    logic          period_end_s;

    assign period_end_s = (cnt_q == CW'(PERIOD - 1));
    assign tx_o         = tx_q;
    assign done_o       = done_s;
    assign idle_o       = (state_q == ST_IDLE);

    // Frame sequencing, bit timing and the registered line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_s  = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                bit_d = 3'd0;
                if (load_i) begin
                    state_d = ST_START;
                    shreg_d = data_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (period_end_s) begin
                    state_d = ST_DATA;
                    cnt_d   = {CW{1'b0}};
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (period_end_s) begin
                    cnt_d   = {CW{1'b0}};
                    shreg_d = {1'b1, shreg_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (period_end_s) begin
                    done_s = 1'b1;
                    cnt_d  = {CW{1'b0}};
                    if (load_i) begin
                        state_d = ST_START;
                        shreg_d = data_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State register; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from three requesters.
// A byte without LAST locks the line to its owner until LAST or a stall timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 9600,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [NREQ-1:0]      REQ_VALID,
    input  logic [8*NREQ-1:0]    REQ_DATA,
    input  logic [NREQ-1:0]      REQ_LAST,
    output logic [NREQ-1:0]      REQ_READY,
    output logic                 TX,
    output logic                 BUSY
);

    localparam int PERIOD     = calc_period(CLK_FREQ, BAUD);
    localparam int TMO_CYCLES = LOCK_TIMEOUT * PERIOD;
    localparam int TW         = $clog2(TMO_CYCLES + 1);

    logic          lock_q, lock_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          sh_idle_s, sh_done_s;
    logic          stall_s, tmo_hit_s, eff_lock_s;
    logic [1:0]    eff_ptr_s, cand_s;
    logic          grant_vld_s;
    logic [1:0]    grant_idx_s;
    logic [NREQ-1:0] ready_s;
    logic [7:0]    data_sel_s;
    logic          last_sel_s;

    uart_tx_shift #(.PERIOD(PERIOD)) u_shift (
        .clk    (CLK),
        .rst_n  (RESETN),
        .load_i (grant_vld_s),
        .data_i (data_sel_s),
        .tx_o   (TX),
        .done_o (sh_done_s),
        .idle_o (sh_idle_s)
    );

    // Owner idle-stall detection; on expiry the lock drops in the same cycle
    // so another requester can be granted immediately.
    assign stall_s    = lock_q && sh_idle_s && !REQ_VALID[owner_q];
    assign tmo_hit_s  = stall_s && (tmo_q == TW'(TMO_CYCLES - 1));
    assign eff_lock_s = lock_q && !tmo_hit_s;
    assign eff_ptr_s  = tmo_hit_s ? add_mod3(owner_q, 2'd1) : ptr_q;

    // Grant selection: owner only while locked, else first valid from the pointer.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 2'd0;
        cand_s      = 2'd0;
        if (RESETN && (sh_idle_s || sh_done_s)) begin
            if (eff_lock_s) begin
                if (REQ_VALID[owner_q]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = owner_q;
                end else begin
                    grant_vld_s = 1'b0;
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    cand_s = add_mod3(eff_ptr_s, 2'(k));
                    if (!grant_vld_s && REQ_VALID[cand_s]) begin
                        grant_vld_s = 1'b1;
                        grant_idx_s = cand_s;
                    end else begin
                        grant_vld_s = grant_vld_s;
                    end
                end
            end
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    // Accept strobe and the selected requester's byte and LAST flag.
    always_comb begin
        ready_s = {NREQ{1'b0}};
        if (grant_vld_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = {NREQ{1'b0}};
        end
        data_sel_s = REQ_DATA[{grant_idx_s, 3'b000} +: 8];
        last_sel_s = REQ_LAST[grant_idx_s];
    end

    assign REQ_READY = ready_s;
    assign BUSY      = !sh_idle_s || lock_q;

    // Lock, owner, pointer and stall-timer updates.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (stall_s && !tmo_hit_s) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = {TW{1'b0}};
        end
        if (tmo_hit_s) begin
            lock_d = 1'b0;
            ptr_d  = eff_ptr_s;
        end else begin
            lock_d = lock_q;
        end
        if (grant_vld_s) begin
            owner_d = grant_idx_s;
            lock_d  = !last_sel_s;
            if (last_sel_s) begin
                ptr_d = add_mod3(grant_idx_s, 2'd1);
            end else begin
                ptr_d = ptr_d;
            end
        end else begin
            owner_d = owner_q;
        end
    end

    // Arbitration state register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            lock_q  <= 1'b0;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            tmo_q   <= {TW{1'b0}};
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short bit period (4 cycles).
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int P   = 4;
    localparam int TMO = 16 * P;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [2:0]  REQ_VALID;
    logic [23:0] REQ_DATA;
    logic [2:0]  REQ_LAST;
    logic [2:0]  REQ_READY;
    logic        TX;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int nacc;
    int acc_req[4];
    int acc_cyc[4];

    logic [9:0] mon_frame[$];
    int         mon_cyc[$];

    uart_tx_arbiter #(.CLK_FREQ(40), .BAUD(10), .LOCK_TIMEOUT(16)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_LAST  (REQ_LAST),
        .REQ_READY (REQ_READY),
        .TX        (TX),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Line monitor: samples each bit near its centre, drops frames cut by reset.
    initial begin
        bit         act;
        int         t;
        int         st;
        logic [9:0] bits;
        act = 1'b0; t = 0; st = 0; bits = 10'h000;
        forever begin
            @(negedge CLK);
            if (RESETN !== 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (TX == 1'b0) begin
                    act = 1'b1; t = 0; st = cyc;
                end
            end else begin
                t = t + 1;
                if (((t - 1) % P) == 0) begin
                    bits[(t - 1) / P] = TX;
                    if (((t - 1) / P) == 9) begin
                        mon_frame.push_back(bits);
                        mon_cyc.push_back(st);
                        act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic wait_frames(input int n);
        for (int w = 0; w < 20 * P * 10; w++) begin
            if (mon_frame.size() >= n) break;
            @(negedge CLK);
        end
        chk("frame_count", 32'(mon_frame.size()), 32'(n));
    endtask

    task automatic pop_frame(input string name, input logic [9:0] exp, output int st);
        logic [9:0] f;
        st = -1;
        f  = 10'h000;
        if (mon_frame.size() > 0) begin
            f  = mon_frame.pop_front();
            st = mon_cyc.pop_front();
        end
        chk(name, {22'd0, f}, {22'd0, exp});
    endtask

    // Present pending requests each cycle, record accepts, retire accepted bits.
    // With do_swap, requester 1's first accept is followed by byte 'B' with LAST.
    task automatic run_arb(input logic [2:0] init, input bit do_swap, input int budget);
        logic [2:0] pending;
        bit         swap;
        int         acc1;
        int         idx;
        pending = init; swap = 1'b0; acc1 = 0; nacc = 0;
        for (int w = 0; w < budget && pending != 3'b000; w++) begin
            if (swap) begin
                REQ_DATA[15:8] = 8'h42;
                REQ_LAST[1]    = 1'b1;
                swap           = 1'b0;
            end
            REQ_VALID = pending;
            #1;
            if (REQ_READY != 3'b000) begin
                chk("ready_without_valid", {29'd0, REQ_READY & ~REQ_VALID}, 32'd0);
                chk("ready_onehot", 32'($countones(REQ_READY)), 32'd1);
                idx = REQ_READY[0] ? 0 : (REQ_READY[1] ? 1 : 2);
                if (nacc < 4) begin
                    acc_req[nacc] = idx;
                    acc_cyc[nacc] = cyc;
                end
                nacc++;
                if (do_swap && REQ_READY[1] && acc1 == 0) begin
                    acc1 = 1;
                    swap = 1'b1;
                end else begin
                    pending = pending & ~REQ_READY;
                end
            end
            @(negedge CLK);
        end
        REQ_VALID = pending;
        chk("all_served", {29'd0, pending}, 32'd0);
    endtask

    typedef struct {
        int         req;
        logic [7:0] data;
        logic [9:0] exp_frame;   // bit k = line level at centre of bit k
    } vec_t;

    initial begin
        vec_t tv[5];
        int   c0;
        int   rel_cyc;
        int   st0, st1, st2;

        tv[0] = '{req: 0, data: 8'h31, exp_frame: 10'b1001100010};
        tv[1] = '{req: 2, data: 8'hA5, exp_frame: 10'b1101001010};
        tv[2] = '{req: 1, data: 8'h00, exp_frame: 10'b1000000000};
        tv[3] = '{req: 1, data: 8'hFF, exp_frame: 10'b1111111110};
        tv[4] = '{req: 2, data: 8'h5A, exp_frame: 10'b1010110100};

        // Reset with all requesters asserting valid.
        RESETN    = 1'b0;
        REQ_VALID = 3'b111;
        REQ_DATA  = 24'h000000;
        REQ_LAST  = 3'b111;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ready", {29'd0, REQ_READY}, 32'd0);
        @(negedge CLK);
        RESETN  = 1'b1;
        rel_cyc = cyc;

        // Single-byte messages, one requester at a time.
        for (int i = 0; i < 5; i++) begin
            REQ_DATA[8*tv[i].req +: 8] = tv[i].data;
            REQ_LAST = 3'b111;
            run_arb(3'b001 << tv[i].req, 1'b0, 20);
            chk("vec_accept_count", 32'(nacc), 32'd1);
            chk("vec_accept_req", 32'(acc_req[0]), 32'(tv[i].req));
            if (i == 0) chk("first_edge_accept", 32'(acc_cyc[0]), 32'(rel_cyc));
            c0 = acc_cyc[0];
            wait_cyc(c0 + FRAME_BITS * P);
            chk("vec_busy_last_stop", {31'd0, BUSY}, 32'd1);
            wait_cyc(c0 + FRAME_BITS * P + 1);
            chk("vec_busy_after", {31'd0, BUSY}, 32'd0);
            wait_frames(1);
            pop_frame("vec_frame", tv[i].exp_frame, st0);
            chk("vec_start_cycle", 32'(st0), 32'(c0 + 1));
        end

        // Round robin: all three valid, pointer at 0.
        REQ_DATA = {8'h33, 8'h32, 8'h31};
        REQ_LAST = 3'b111;
        run_arb(3'b111, 1'b0, 200);
        chk("rr_count", 32'(nacc), 32'd3);
        chk("rr_order0", 32'(acc_req[0]), 32'd0);
        chk("rr_order1", 32'(acc_req[1]), 32'd1);
        chk("rr_order2", 32'(acc_req[2]), 32'd2);
        chk("rr_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(10 * P));
        chk("rr_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(10 * P));
        wait_frames(3);
        pop_frame("rr_frame1", {1'b1, 8'h31, 1'b0}, st0);
        pop_frame("rr_frame2", {1'b1, 8'h32, 1'b0}, st1);
        pop_frame("rr_frame3", {1'b1, 8'h33, 1'b0}, st2);

        // Locked message "AB" from requester 1 while requester 2 waits with "Z".
        REQ_DATA = {8'h5A, 8'h41, 8'h00};
        REQ_LAST = 3'b101;
        run_arb(3'b110, 1'b1, 400);
        chk("lock_count", 32'(nacc), 32'd3);
        chk("lock_order0", 32'(acc_req[0]), 32'd1);
        chk("lock_order1", 32'(acc_req[1]), 32'd1);
        chk("lock_order2", 32'(acc_req[2]), 32'd2);
        wait_frames(3);
        pop_frame("lock_frame_a", {1'b1, 8'h41, 1'b0}, st0);
        pop_frame("lock_frame_b", {1'b1, 8'h42, 1'b0}, st1);
        pop_frame("lock_frame_z", {1'b1, 8'h5A, 1'b0}, st2);
        chk("lock_ab_gap", 32'(st1 - st0), 32'(10 * P));
        chk("lock_bz_gap", 32'(st2 - st1), 32'(10 * P));

        // Lock timeout: requester 0 leaves its message open, requester 2 waits.
        REQ_DATA = {8'h33, 8'h00, 8'h55};
        REQ_LAST = 3'b110;
        run_arb(3'b001, 1'b0, 20);
        c0 = acc_cyc[0];
        wait_cyc(c0 + 10 * P + 3);
        REQ_VALID = 3'b100;
        #1;
        chk("tmo_locked_no_ready", {29'd0, REQ_READY}, 32'd0);
        chk("tmo_locked_busy", {31'd0, BUSY}, 32'd1);
        run_arb(3'b100, 1'b0, 300);
        chk("tmo_req", 32'(acc_req[0]), 32'd2);
        chk("tmo_delay", 32'(acc_cyc[0] - c0), 32'(10 * P + TMO));
        wait_frames(2);
        pop_frame("tmo_frame0", {1'b1, 8'h55, 1'b0}, st0);
        pop_frame("tmo_frame2", {1'b1, 8'h33, 1'b0}, st1);

        // Reset during data bit 3, then a fresh byte must go out intact.
        REQ_DATA = 24'h000000;
        REQ_LAST = 3'b111;
        run_arb(3'b001, 1'b0, 20);
        c0 = acc_cyc[0];
        wait_cyc(c0 + 4 * P + 2);
        chk("mid_bit3_low", {31'd0, TX}, 32'd0);
        REQ_DATA[15:8] = 8'hA5;
        REQ_VALID      = 3'b010;
        RESETN         = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, TX}, 32'd1);
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_ready", {29'd0, REQ_READY}, 32'd0);
        repeat (3) @(negedge CLK);
        RESETN  = 1'b1;
        rel_cyc = cyc;
        run_arb(3'b010, 1'b0, 5);
        chk("midrst_accept_cycle", 32'(acc_cyc[0]), 32'(rel_cyc));
        wait_frames(1);
        pop_frame("midrst_frame", 10'b1101001010, st0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d reached without completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
